key_schedule_feeder: RTL and testbench
======================================

KEY_SCHEDULE_FEEDER -- requirements
Module: key_schedule_feeder

Interface
REQ-001 SHALL have parameter KEY_W, 12, width of one key word and of key_out.
REQ-002 SHALL have parameter NUM_KEYS, 4, number of keys in the schedule.
REQ-003 SHALL have parameter WIN_LEN, 5, cycles per key window; period = NUM_KEYS*WIN_LEN = 20.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on the falling edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port clear, input, 1, synchronous return to EMPTY with key storage zeroed.
REQ-007 SHALL have port load_valid, input, 1, serial key bit offered.
REQ-008 SHALL have port load_bit, input, 1, serial key data.
REQ-009 SHALL have port load_ready, output, 1, block accepts a key bit this cycle.
REQ-010 SHALL have port start, input, 1, begin driving the schedule (honoured only in ARMED).
REQ-011 SHALL have port key_out, output, KEY_W, key bus to the downstream locked FSM; bit i drives keyinput i.
REQ-012 SHALL have port window, output, 2, current window index = phase/WIN_LEN.
REQ-013 SHALL have port phase, output, 5, free-running phase counter, 0..19.
REQ-014 SHALL have port armed, output, 1, all keys loaded.
REQ-015 SHALL have port running, output, 1, schedule being driven.

Function
REQ-016 SHALL advance phase on every falling edge: 19 wraps to 0, otherwise +1, in every state, so phase equals the downstream window counter between edges.
REQ-017 SHALL compute window combinationally: 0 for phase 0-4, 1 for 5-9, 2 for 10-14, 3 for 15-19.
REQ-018 SHALL implement the FSM EMPTY -> LOADING -> ARMED -> RUNNING.
REQ-019 SHALL assert load_ready only in EMPTY and LOADING; a bit is accepted when load_valid && load_ready at a falling edge.
REQ-020 SHALL store serial bits in acceptance order: bits 0-11 form key 0, 12-23 key 1, and so on; within a key, the first bit is key bit 0.
REQ-021 SHALL keep a 6-bit accepted-bit count, 0..47; the first accepted bit moves EMPTY -> LOADING.
REQ-022 SHALL, on acceptance of bit 47, move to ARMED, set armed=1 and deassert load_ready from the next cycle.
REQ-023 SHALL move ARMED -> RUNNING when start=1; start in any other state is ignored.
REQ-024 SHALL drive key_out = key[window] combinationally in RUNNING; key changes only at window boundaries (phase 4->5, 9->10, 14->15, 19->0).
REQ-025 SHALL drive key_out = 0 in EMPTY, LOADING and ARMED.
REQ-026 SHALL remain in RUNNING until clear or rst, and ignore load_valid there.
REQ-027 SHALL give clear priority over start and load_valid in the same cycle; after clear, state=EMPTY, count=0, keys=0, and phase keeps counting.
REQ-028 SHALL, on clear during LOADING, discard the partial key set; the next accepted bit is bit 0 of key 0.

Reset
REQ-029 SHALL, on rst, set state=EMPTY, phase=0, count=0, all keys=0, key_out=0, window=0, armed=0, running=0, load_ready=1 immediately (asynchronous).
REQ-030 SHALL, on rst mid-load or mid-run, abandon the operation; storage contents are not preserved.

Structure
REQ-031 SHALL place the FSM state enum and the KEY_W, NUM_KEYS and WIN_LEN defaults in a shared package key_sched_pkg.
REQ-032 SHALL contain one sub-module, key_phase_counter, holding the phase register and the window decode.

Verification
REQ-033 Reset, then load 48 bits for keys 734, 835, 2660 and 1905 with their bin strings sent first char first (first key '001011011110'), then start -> key_out[0..11] follows 001011011110 / 001101000011 / 101001100100 / 011101110001 for windows 0-3.
REQ-034 Phase 19 -> next falling edge gives phase=0, window=0 and key_out returns to key 0.
REQ-035 Apply clear after 20 bits, then send 48 new bits -> armed only after the 48th new bit; the earlier 20 bits have no effect.
REQ-036 Assert start while in LOADING (bit 30) -> state and key_out unchanged (0); start after armed -> running=1.
REQ-037 Assert rst while running at phase 7 -> all outputs 0 asynchronously and load_ready=1; phase restarts at 0.
REQ-038 Assert clear and start together in ARMED -> EMPTY, running=0, key_out=0.

Source files
------------

// File: rtl/key_sched_pkg.sv
// Shared definitions for the key schedule feeder: FSM states and default geometry.
package key_sched_pkg;

    localparam int KEY_W_DEF    = 12;
    localparam int NUM_KEYS_DEF = 4;
    localparam int WIN_LEN_DEF  = 5;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_ARMED   = 2'd2,
        ST_RUNNING = 2'd3
    } state_t;

endpackage

// File: rtl/key_phase_counter.sv
// Free-running schedule phase counter (falling edge) and its key-window decode.
module key_phase_counter
    import key_sched_pkg::*;
#(
    parameter int NUM_KEYS = NUM_KEYS_DEF,
    parameter int WIN_LEN  = WIN_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    output logic [4:0] phase,
    output logic [1:0] window
);

    localparam int PERIOD = NUM_KEYS * WIN_LEN;

    logic [4:0] phase_reg;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            phase_reg <= '0;
        end else if (phase_reg == 5'(PERIOD - 1)) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_reg + 5'd1;
        end
    end

    // Boundary compare chain instead of a divider on the phase path.
    always_comb begin
        window = '0;
        for (int w = 1; w < NUM_KEYS; w++) begin
            if (int'(phase_reg) >= w * WIN_LEN) begin
                window = 2'(w);
            end
        end
    end

    assign phase = phase_reg;

endmodule

// File: rtl/key_schedule_feeder.sv
// Serially loads a key schedule, then drives one key per phase window to a downstream locked FSM.
module key_schedule_feeder
    import key_sched_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int NUM_KEYS = NUM_KEYS_DEF,
    parameter int WIN_LEN  = WIN_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load_valid,
    input  logic             load_bit,
    output logic             load_ready,
    input  logic             start,
    output logic [KEY_W-1:0] key_out,
    output logic [1:0]       window,
    output logic [4:0]       phase,
    output logic             armed,
    output logic             running
);

    localparam int TOTAL_BITS = KEY_W * NUM_KEYS;

    state_t                  state_reg;
    state_t                  state_next;
    logic [5:0]              count_reg;
    logic [TOTAL_BITS-1:0]   key_bits_reg;
    logic [KEY_W-1:0]        key_words [NUM_KEYS];
    logic                    accept;
    logic                    last_bit;

    key_phase_counter #(
        .NUM_KEYS (NUM_KEYS),
        .WIN_LEN  (WIN_LEN)
    ) u_phase (
        .clk    (clk),
        .rst    (rst),
        .phase  (phase),
        .window (window)
    );

    assign accept   = load_valid && load_ready;
    assign last_bit = (count_reg == 6'(TOTAL_BITS - 1));

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY, ST_LOADING: begin
                if (accept) begin
                    state_next = last_bit ? ST_ARMED : ST_LOADING;
                end
            end
            ST_ARMED: begin
                if (start) begin
                    state_next = ST_RUNNING;
                end
            end
            default: state_next = state_reg;
        endcase
        if (clear) begin
            state_next = ST_EMPTY;
        end
    end

    always_comb begin
        load_ready = 1'b0;
        armed      = 1'b0;
        running    = 1'b0;
        case (state_reg)
            ST_EMPTY, ST_LOADING: load_ready = 1'b1;
            ST_ARMED:             armed      = 1'b1;
            ST_RUNNING: begin
                armed   = 1'b1;
                running = 1'b1;
            end
            default: ;
        endcase
    end

    // Bit n of the serial stream lands at flat position n, so key k bit 0 is its first bit.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            count_reg    <= '0;
            key_bits_reg <= '0;
        end else if (clear) begin
            count_reg    <= '0;
            key_bits_reg <= '0;
        end else if (accept) begin
            key_bits_reg[count_reg] <= load_bit;
            if (!last_bit) begin
                count_reg <= count_reg + 6'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key_words
            assign key_words[gi] = key_bits_reg[gi*KEY_W +: KEY_W];
        end
    endgenerate

    always_comb begin
        key_out = '0;
        if (state_reg == ST_RUNNING) begin
            key_out = key_words[window];
        end
    end

endmodule

// File: tb/tb_key_schedule_feeder.sv
// Directed bench for key_schedule_feeder with a key_out scoreboard during the running schedule.
module tb_key_schedule_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_bit = 1'b0;
    logic        start = 1'b0;
    logic        load_ready;
    logic [11:0] key_out;
    logic [1:0]  window;
    logic [4:0]  phase;
    logic        armed;
    logic        running;

    int          checks = 0;
    int          errors = 0;
    int          tb_phase = 0;
    logic [11:0] cur_keys [4];
    logic [11:0] exp_q [$];

    key_schedule_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .load_valid (load_valid),
        .load_bit   (load_bit),
        .load_ready (load_ready),
        .start      (start),
        .key_out    (key_out),
        .window     (window),
        .phase      (phase),
        .armed      (armed),
        .running    (running)
    );

    always #5 clk = ~clk;

    // Reference phase: falling-edge counter 0..19, cleared only by rst.
    always @(negedge clk or posedge rst) begin
        if (rst) tb_phase <= 0;
        else     tb_phase <= (tb_phase == 19) ? 0 : tb_phase + 1;
    end

    function automatic logic [11:0] rev12(input logic [11:0] v);
        logic [11:0] r;
        for (int i = 0; i < 12; i++) r[i] = v[11-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic st);
        load_valid = 1'b1;
        load_bit   = b;
        start      = st;
        @(posedge clk);
        load_valid = 1'b0;
        load_bit   = 1'b0;
        start      = 1'b0;
    endtask

    // Keys are sent as binary strings, first character (MSB of the value) first.
    task automatic load_set(input logic [11:0] k0, input logic [11:0] k1,
                            input logic [11:0] k2, input logic [11:0] k3,
                            input int start_at);
        logic [11:0] ks [4];
        ks[0] = k0; ks[1] = k1; ks[2] = k2; ks[3] = k3;
        for (int n = 0; n < 48; n++) begin
            if (n == 47) begin
                chk("pre_arm_armed", armed, 0);
                chk("pre_arm_ready", load_ready, 1);
            end
            send_bit(ks[n/12][11 - (n % 12)], n == start_at);
            if (n == start_at) begin
                chk("start_in_loading_running", running, 0);
                chk("start_in_loading_key", key_out, 0);
                chk("start_in_loading_ready", load_ready, 1);
            end
        end
        chk("armed", armed, 1);
        chk("armed_ready", load_ready, 0);
        chk("armed_key", key_out, 0);
        chk("armed_running", running, 0);
        for (int k = 0; k < 4; k++) cur_keys[k] = rev12(ks[k]);
    endtask

    task automatic start_run();
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        chk("start_running", running, 1);
        chk("start_ready", load_ready, 0);
    endtask

    task automatic run_check(input int n);
        int          nxt;
        logic [11:0] e;
        for (int c = 0; c < n; c++) begin
            nxt = (tb_phase == 19) ? 0 : tb_phase + 1;
            exp_q.push_back(cur_keys[nxt/5]);
            @(posedge clk);
            e = exp_q.pop_front();
            chk("run_key", key_out, e);
            chk("run_window", window, nxt / 5);
            chk("run_phase", phase, nxt);
        end
    endtask

    task automatic wait_phase(input int target);
        int n = 0;
        while (phase !== 5'(target) && n < 40) begin
            @(posedge clk);
            n++;
        end
        chk("reach_phase", phase, target);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        chk("rst_ready", load_ready, 1);
        chk("rst_armed", armed, 0);
        chk("rst_running", running, 0);
        chk("rst_key", key_out, 0);
        chk("rst_window", window, 0);
        chk("rst_phase", phase, 0);
        rst = 1'b0;

        // Keys 734, 835, 2660, 1905.
        load_set(12'd734, 12'd835, 12'd2660, 12'd1905, -1);
        start_run();
        run_check(25);

        wait_phase(19);
        @(posedge clk);
        chk("wrap_phase", phase, 0);
        chk("wrap_window", window, 0);
        chk("wrap_key", key_out, rev12(12'd734));

        // Asynchronous reset while running at phase 7.
        wait_phase(7);
        rst = 1'b1;
        #1;
        chk("arst_key", key_out, 0);
        chk("arst_running", running, 0);
        chk("arst_armed", armed, 0);
        chk("arst_ready", load_ready, 1);
        chk("arst_phase", phase, 0);
        chk("arst_window", window, 0);
        @(posedge clk);
        rst = 1'b0;
        @(posedge clk);
        chk("post_rst_phase", phase, 1);

        // Partial load, clear (with a competing bit), then a full new set with start at bit 30.
        for (int n = 0; n < 20; n++) send_bit(1'b1, 1'b0);
        clear = 1'b1; load_valid = 1'b1; load_bit = 1'b1;
        @(posedge clk);
        clear = 1'b0; load_valid = 1'b0; load_bit = 1'b0;
        chk("clr_ready", load_ready, 1);
        chk("clr_armed", armed, 0);
        chk("clr_key", key_out, 0);
        chk("clr_phase", phase, tb_phase);
        load_set(12'h5A3, 12'h0F1, 12'hC3C, 12'h777, 30);
        start_run();
        run_check(20);

        // Clear out of RUNNING, reload, then clear and start together in ARMED.
        clear = 1'b1;
        @(posedge clk);
        clear = 1'b0;
        chk("clr_run_running", running, 0);
        chk("clr_run_key", key_out, 0);
        load_set(12'hABC, 12'h123, 12'h456, 12'h789, -1);
        clear = 1'b1; start = 1'b1;
        @(posedge clk);
        clear = 1'b0; start = 1'b0;
        chk("clr_start_armed", armed, 0);
        chk("clr_start_running", running, 0);
        chk("clr_start_key", key_out, 0);
        chk("clr_start_ready", load_ready, 1);
        chk("clr_start_phase", phase, tb_phase);
        repeat (3) @(posedge clk);
        chk("idle_running", running, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
